// File: rtl/arb_bus_master.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// arb_bus_master
//
// Requester-side agent for the three-master arbitrated bus. One instance sits
// in front of each master. It takes a burst command from local logic, requests
// the bus with req_n, and after grant drives frame_n/irdy_n and ad_out for
// cmd_len+1 data beats. When the burst ends it returns the bus to the idle
// signature (frame_n=1, irdy_n=1), which the arbiter uses to end the tenure.
// If no grant arrives within GNT_TIMEOUT cycles the request is abandoned.
//
// Ports:
//   clk          clock, all activity on rising edge
//   reset        asynchronous, active-low reset
//   cmd_valid    local command valid (sampled only while idle)
//   cmd_ready    high while idle; a command is taken when cmd_valid=1
//   cmd_len      burst length minus one
//   cmd_base     data of beat 0; beat i carries cmd_base+i
//   req_n        bus request to the arbiter, active-low
//   gnt_n        bus grant from the arbiter, active-low
//   frame_n      transaction frame, active-low; rises with the last beat
//   irdy_n       initiator ready, active-low; low for the whole burst
//   trdy_n       target ready, active-low; high inserts wait states
//   ad_out       data presented during the burst
//   ad_oe        drive enable for ad_out
//   xfer_done    one-cycle pulse after the last beat completes
//   gnt_timeout  one-cycle pulse when the request is abandoned
//   busy         agent is not idle
// -----------------------------------------------------------------------------
module arb_bus_master #(
  parameter int DATA_W      = 32,
  parameter int LEN_W       = 4,
  parameter int GNT_TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] cmd_base,
  output logic              req_n,
  input  logic              gnt_n,
  output logic              frame_n,
  output logic              irdy_n,
  input  logic              trdy_n,
  output logic [DATA_W-1:0] ad_out,
  output logic              ad_oe,
  output logic              xfer_done,
  output logic              gnt_timeout,
  output logic              busy
);

  localparam int TW = $clog2(GNT_TIMEOUT);
  localparam logic [TW-1:0] TO_LAST = TW'(GNT_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE = 4'b0001,
    S_REQ  = 4'b0010,
    S_XFER = 4'b0100,
    S_DONE = 4'b1000
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  // Registered bus-facing outputs and counters
  logic              r_req_n;
  logic              r_frame_n;
  logic              r_irdy_n;
  logic              r_ad_oe;
  logic [DATA_W-1:0] r_ad_out;
  logic              r_xfer_done;
  logic              r_gnt_timeout;
  logic [LEN_W-1:0]  r_idx;
  logic [TW-1:0]     r_tcnt;

  // Latched command
  logic [LEN_W-1:0]  r_len;
  logic [DATA_W-1:0] r_base;

  // Next values for the registered outputs
  logic              w_req_n_nxt;
  logic              w_frame_n_nxt;
  logic              w_irdy_n_nxt;
  logic              w_ad_oe_nxt;
  logic [DATA_W-1:0] w_ad_out_nxt;
  logic              w_xfer_done_nxt;
  logic              w_gnt_timeout_nxt;
  logic [LEN_W-1:0]  w_idx_nxt;
  logic [TW-1:0]     w_tcnt_nxt;

  logic              w_accept;
  logic              w_beat_done;
  logic              w_last;
  logic              w_to_hit;
  logic [LEN_W-1:0]  w_idx_inc;

  assign w_accept    = (r_state == S_IDLE) && cmd_valid;
  assign w_beat_done = !r_irdy_n && !trdy_n;
  assign w_last      = (r_idx == r_len);
  assign w_to_hit    = (r_tcnt == TO_LAST);
  assign w_idx_inc   = r_idx + LEN_W'(1);

  // State and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state       <= S_IDLE;
      r_req_n       <= 1'b1;
      r_frame_n     <= 1'b1;
      r_irdy_n      <= 1'b1;
      r_ad_oe       <= 1'b0;
      r_ad_out      <= '0;
      r_xfer_done   <= 1'b0;
      r_gnt_timeout <= 1'b0;
      r_idx         <= '0;
      r_tcnt        <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_req_n       <= w_req_n_nxt;
      r_frame_n     <= w_frame_n_nxt;
      r_irdy_n      <= w_irdy_n_nxt;
      r_ad_oe       <= w_ad_oe_nxt;
      r_ad_out      <= w_ad_out_nxt;
      r_xfer_done   <= w_xfer_done_nxt;
      r_gnt_timeout <= w_gnt_timeout_nxt;
      r_idx         <= w_idx_nxt;
      r_tcnt        <= w_tcnt_nxt;
    end
  end

  // Command capture; only meaningful once accepted, so no reset needed
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_len  <= cmd_len;
      r_base <= cmd_base;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (cmd_valid) w_state_nxt = S_REQ;
      S_REQ: begin
        // Grant takes priority over a timeout on the same edge
        if (!gnt_n)        w_state_nxt = S_XFER;
        else if (w_to_hit) w_state_nxt = S_IDLE;
      end
      S_XFER: if (w_beat_done && w_last) w_state_nxt = S_DONE;
      S_DONE: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs
  always_comb begin
    w_req_n_nxt       = 1'b1;
    w_frame_n_nxt     = 1'b1;
    w_irdy_n_nxt      = 1'b1;
    w_ad_oe_nxt       = 1'b0;
    w_ad_out_nxt      = r_ad_out;
    w_xfer_done_nxt   = 1'b0;
    w_gnt_timeout_nxt = 1'b0;
    w_idx_nxt         = r_idx;
    w_tcnt_nxt        = r_tcnt;
    case (r_state)
      S_IDLE: begin
        if (cmd_valid) begin
          w_req_n_nxt = 1'b0;
          w_tcnt_nxt  = '0;
        end
      end
      S_REQ: begin
        if (!gnt_n) begin
          w_ad_oe_nxt   = 1'b1;
          w_irdy_n_nxt  = 1'b0;
          w_ad_out_nxt  = r_base;
          w_idx_nxt     = '0;
          // A single-beat burst presents its only (last) beat without frame
          w_frame_n_nxt = (r_len == '0);
        end else if (w_to_hit) begin
          w_gnt_timeout_nxt = 1'b1;
        end else begin
          w_req_n_nxt = 1'b0;
          w_tcnt_nxt  = r_tcnt + TW'(1);
        end
      end
      S_XFER: begin
        // Wait states hold everything as presented
        w_ad_oe_nxt   = 1'b1;
        w_irdy_n_nxt  = 1'b0;
        w_frame_n_nxt = r_frame_n;
        if (w_beat_done) begin
          if (w_last) begin
            w_ad_oe_nxt     = 1'b0;
            w_irdy_n_nxt    = 1'b1;
            w_frame_n_nxt   = 1'b1;
            w_xfer_done_nxt = 1'b1;
          end else begin
            w_idx_nxt     = w_idx_inc;
            w_ad_out_nxt  = r_base + DATA_W'(w_idx_inc);
            // frame_n rises as the final beat is put on the bus
            w_frame_n_nxt = (w_idx_inc == r_len);
          end
        end
      end
      default: ;
    endcase
  end

  assign cmd_ready   = (r_state == S_IDLE);
  assign busy        = (r_state != S_IDLE);
  assign req_n       = r_req_n;
  assign frame_n     = r_frame_n;
  assign irdy_n      = r_irdy_n;
  assign ad_oe       = r_ad_oe;
  assign ad_out      = r_ad_out;
  assign xfer_done   = r_xfer_done;
  assign gnt_timeout = r_gnt_timeout;

  // Bus protocol invariants
  a_onehot:   assert property (@(posedge clk) disable iff (!reset) $onehot(r_state));
  a_frame:    assert property (@(posedge clk) disable iff (!reset) !r_frame_n |-> !r_irdy_n);
  a_req:      assert property (@(posedge clk) disable iff (!reset) !r_req_n |-> (r_state == S_REQ));
  a_oe:       assert property (@(posedge clk) disable iff (!reset) r_ad_oe |-> (r_state == S_XFER));
  a_idle_bus: assert property (@(posedge clk) disable iff (!reset)
                               (r_state != S_XFER) |-> (r_frame_n && r_irdy_n));

endmodule

// File: tb/tb_arb_bus_master.sv
`timescale 1ns/1ps
// Bench for arb_bus_master: reset state, table of directed bursts, reset
// mid-burst, back-to-back commands with data wrap, and randomized bursts
// checked cycle by cycle against a transaction-level expectation.
module tb_arb_bus_master;
  localparam int DATA_W      = 32;
  localparam int LEN_W       = 4;
  localparam int GNT_TIMEOUT = 16;

  // Status vector order: {req_n, frame_n, irdy_n, ad_oe, xfer_done, gnt_timeout, busy, cmd_ready}
  localparam logic [7:0] IDLE_ST = 8'b1110_0001;
  localparam logic [7:0] REQ_ST  = 8'b0110_0010;
  localparam logic [7:0] TO_ST   = 8'b1110_0101;
  localparam logic [7:0] DONE_ST = 8'b1110_1010;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic [LEN_W-1:0]  cmd_len = '0;
  logic [DATA_W-1:0] cmd_base = '0;
  logic              req_n;
  logic              gnt_n = 1'b1;
  logic              frame_n;
  logic              irdy_n;
  logic              trdy_n = 1'b1;
  logic [DATA_W-1:0] ad_out;
  logic              ad_oe;
  logic              xfer_done;
  logic              gnt_timeout;
  logic              busy;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  arb_bus_master #(
    .DATA_W(DATA_W), .LEN_W(LEN_W), .GNT_TIMEOUT(GNT_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_len(cmd_len), .cmd_base(cmd_base), .req_n(req_n), .gnt_n(gnt_n),
    .frame_n(frame_n), .irdy_n(irdy_n), .trdy_n(trdy_n), .ad_out(ad_out),
    .ad_oe(ad_oe), .xfer_done(xfer_done), .gnt_timeout(gnt_timeout), .busy(busy)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] st();
    return {req_n, frame_n, irdy_n, ad_oe, xfer_done, gnt_timeout, busy, cmd_ready};
  endfunction

  function automatic logic [7:0] xfer_st(input logic fr);
    return {1'b1, fr, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Protocol invariants, sampled mid-cycle
  always @(negedge clk) begin
    if (reset === 1'b1)
      chk("invariants", 64'({(!frame_n && irdy_n), (!req_n && !busy), (ad_oe && !busy)}), 64'd0);
  end

  // One command from IDLE back to IDLE. Grant is given so that it is sampled
  // gdelay cycles after the accept edge; beyond GNT_TIMEOUT it never comes.
  task automatic run_txn(input int len, input logic [31:0] base, input int gdelay,
                         input int wbeat, input int wcnt, input bit rnd, input bit hold,
                         output int req_c, output int xfer_c, output bit to,
                         output logic [31:0] last);
    int w;
    logic [31:0] e;
    req_c = 0; xfer_c = 0; to = 1'b0; last = '0;
    chk("idle_pre", 64'(st()), 64'(IDLE_ST));
    cmd_len = LEN_W'(len); cmd_base = base; cmd_valid = 1'b1; gnt_n = 1'b1; trdy_n = 1'b1;
    step();
    for (int c = 1; c <= GNT_TIMEOUT; c++) begin
      chk("req_phase", 64'(st()), 64'(REQ_ST));
      req_c++;
      cmd_valid = rnd ? 1'($urandom) : hold;
      if (rnd) begin cmd_len = LEN_W'($urandom); cmd_base = $urandom; end
      gnt_n = (c == gdelay) ? 1'b0 : 1'b1;
      step();
      if (c == gdelay) break;
    end
    if (gdelay > GNT_TIMEOUT) begin
      to = 1'b1;
      chk("timeout_pulse", 64'(st()), 64'(TO_ST));
      cmd_valid = 1'b0; gnt_n = 1'b1;
      step();
      chk("timeout_after", 64'(st()), 64'(IDLE_ST));
      cmd_valid = hold;
      return;
    end
    for (int i = 0; i <= len; i++) begin
      w = rnd ? int'($urandom_range(0, 2)) : ((i == wbeat) ? wcnt : 0);
      e = base + 32'(i);
      for (int j = 0; j <= w; j++) begin
        chk("xfer_ctl", 64'(st()), 64'(xfer_st(i == len)));
        chk("xfer_data", 64'(ad_out), 64'(e));
        xfer_c++;
        last = ad_out;
        trdy_n = (j < w);
        if (rnd) begin
          gnt_n = 1'($urandom); cmd_valid = 1'($urandom);
          cmd_len = LEN_W'($urandom); cmd_base = $urandom;
        end else begin
          gnt_n = 1'b1; cmd_valid = hold;
        end
        step();
      end
    end
    chk("done_pulse", 64'(st()), 64'(DONE_ST));
    trdy_n = 1'b1; gnt_n = 1'b1;
    cmd_valid = rnd ? 1'($urandom) : hold;
    step();
    chk("idle_post", 64'(st()), 64'(IDLE_ST));
    cmd_valid = hold;
  endtask

  typedef struct {
    int          len;
    logic [31:0] base;
    int          gdelay;
    int          wbeat;
    int          wcnt;
    int          exp_req;
    int          exp_xfer;
    bit          exp_to;
    logic [31:0] exp_last;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int          rq, xc;
    bit          tflag;
    logic [31:0] lst;

    tbl[0] = '{0,  32'h0000_00A5, 2,   0,  0, 2,  1,  1'b0, 32'h0000_00A5};  // single beat
    tbl[1] = '{3,  32'h0000_0010, 1,   1,  2, 1,  6,  1'b0, 32'h0000_0013};  // waits on beat 1
    tbl[2] = '{1,  32'h0000_0000, 100, 0,  0, 16, 0,  1'b1, 32'h0000_0000};  // no grant
    tbl[3] = '{0,  32'h0000_0055, 16,  0,  0, 16, 1,  1'b0, 32'h0000_0055};  // grant on timeout edge
    tbl[4] = '{2,  32'h0000_0077, 17,  0,  0, 16, 0,  1'b1, 32'h0000_0000};  // grant one cycle late
    tbl[5] = '{15, 32'h0000_0100, 3,   15, 1, 3,  17, 1'b0, 32'h0000_010F};  // max length
    tbl[6] = '{2,  32'hFFFF_FFFE, 1,   0,  0, 1,  3,  1'b0, 32'h0000_0000};  // data wrap

    // Asynchronous reset state
    #2 reset = 1'b0;
    #1;
    chk("reset_ctl", 64'(st()), 64'(IDLE_ST));
    chk("reset_data", 64'(ad_out), 64'd0);
    step();
    step();
    #3 reset = 1'b1;
    step();
    chk("post_reset", 64'(st()), 64'(IDLE_ST));

    for (int k = 0; k < 7; k++) begin
      run_txn(tbl[k].len, tbl[k].base, tbl[k].gdelay, tbl[k].wbeat, tbl[k].wcnt,
              1'b0, 1'b0, rq, xc, tflag, lst);
      chk($sformatf("tbl%0d_req_cycles", k), 64'(rq), 64'(tbl[k].exp_req));
      chk($sformatf("tbl%0d_xfer_cycles", k), 64'(xc), 64'(tbl[k].exp_xfer));
      chk($sformatf("tbl%0d_timeout", k), 64'(tflag), 64'(tbl[k].exp_to));
      if (!tbl[k].exp_to)
        chk($sformatf("tbl%0d_last_data", k), 64'(lst), 64'(tbl[k].exp_last));
    end

    // Reset asserted during beat 2 of an 8-beat burst
    cmd_len = 4'd7; cmd_base = 32'h0000_0200; cmd_valid = 1'b1; gnt_n = 1'b1; trdy_n = 1'b0;
    step();
    cmd_valid = 1'b0; gnt_n = 1'b0;
    step();
    gnt_n = 1'b1;
    step();
    step();
    chk("rst_mid_pre_data", 64'(ad_out), 64'h202);
    chk("rst_mid_pre_ctl", 64'(st()), 64'(xfer_st(1'b0)));
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_ctl", 64'(st()), 64'(IDLE_ST));
    chk("rst_mid_data", 64'(ad_out), 64'd0);
    trdy_n = 1'b1;
    @(posedge clk);
    #3 reset = 1'b1;
    step();
    for (int c = 0; c < 3; c++) begin
      chk("rst_mid_after", 64'(st()), 64'(IDLE_ST));
      step();
    end

    // Back-to-back with cmd_valid held high across both bursts
    run_txn(2, 32'hFFFF_FFFE, 1, 0, 0, 1'b0, 1'b1, rq, xc, tflag, lst);
    chk("b2b_first_last", 64'(lst), 64'h0);
    run_txn(2, 32'hFFFF_FFFE, 2, 0, 0, 1'b0, 1'b0, rq, xc, tflag, lst);
    chk("b2b_second_xfer", 64'(xc), 64'd3);
    chk("b2b_second_last", 64'(lst), 64'h0);

    // Randomized bursts
    for (int n = 0; n < 40; n++) begin
      run_txn(int'($urandom_range(0, 15)), $urandom, int'($urandom_range(1, 19)),
              0, 0, 1'b1, 1'b0, rq, xc, tflag, lst);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/arb_bus_master.md
Name: arb_bus_master

Overview:
- Requester-side agent for the three-master arbitrated bus. One instance sits in front of each master.
- Accepts a burst command from local logic and requests the bus with active-low req_n.
- After grant, drives frame_n, irdy_n and the address/data bus for the commanded number of data beats, then releases the bus to the idle signature (frame_n=1, irdy_n=1). The arbiter uses that signature to end the tenure.

Parameters:
DATA_W, 32, width of the ad_out bus and of cmd_base
LEN_W, 4, width of cmd_len; burst length in beats = cmd_len+1 (1..16 at default)
GNT_TIMEOUT, 16, cycles spent in REQ without grant before the request is abandoned (must be >= 2)

Ports:
clk  input  1  clock, all activity on rising edge
reset  input  1  asynchronous, active-low reset
cmd_valid  input  1  local command valid
cmd_ready  output  1  block can accept a command (high only in IDLE)
cmd_len  input  LEN_W  beats minus one
cmd_base  input  DATA_W  data value of beat 0; beat i carries cmd_base+i (modulo 2^DATA_W)
req_n  output  1  bus request to arbiter, active-low
gnt_n  input  1  bus grant from arbiter, active-low
frame_n  output  1  transaction frame, active-low
irdy_n  output  1  initiator ready, active-low
trdy_n  input  1  target ready, active-low
ad_out  output  DATA_W  data driven during XFER
ad_oe  output  1  ad_out valid/drive enable
xfer_done  output  1  one-cycle pulse: burst completed
gnt_timeout  output  1  one-cycle pulse: request abandoned
busy  output  1  state != IDLE

Behaviour:
- State machine, one-hot: IDLE, REQ, XFER, DONE. All bus outputs are registered. cmd_ready and busy are decoded from state.
- Reset (asynchronous, reset=0) applies these values immediately:
  - state=IDLE, req_n=1, frame_n=1, irdy_n=1, ad_oe=0, ad_out=0.
  - xfer_done=0, gnt_timeout=0, busy=0, cmd_ready=1.
  - Beat counter and timeout counter cleared.
- IDLE:
  - Command accepted at edge T when cmd_valid=1.
  - Latch cmd_len and cmd_base, go to REQ. req_n=0 from T.
  - Timeout counter cleared.
- REQ:
  - req_n held 0; timeout counter increments each cycle.
  - gnt_n sampled 0 at edge T+k: go to XFER. From T+k: req_n=1, ad_oe=1, irdy_n=0, ad_out=cmd_base, beat index 0.
  - frame_n=0 from T+k, except frame_n=1 if the burst is a single beat.
  - Timeout counter reaching GNT_TIMEOUT-1 with gnt_n=1: go to IDLE. req_n=1 and a gnt_timeout pulse for one cycle.
  - If grant and timeout occur on the same edge, grant wins.
- XFER:
  - A beat completes at an edge where irdy_n=0 and trdy_n=0. trdy_n=1 inserts wait states: ad_out, frame_n and irdy_n are held unchanged.
  - On completion of beat i (not last): ad_out=cmd_base+i+1, index increments.
  - When the next beat to present is the last one (index==cmd_len), frame_n=1 while irdy_n stays 0.
  - Completion of the last beat: go to DONE. frame_n=1, irdy_n=1, ad_oe=0, xfer_done=1 for that one cycle.
  - gnt_n deassertion during XFER is ignored. The arbiter does not preempt; the burst always finishes.
- DONE: lasts exactly one cycle, then go to IDLE. The next command can be accepted one cycle after DONE.
- cmd_valid outside IDLE is ignored (cmd_ready=0).
- Reset asserted mid-burst returns all outputs to reset values in the same cycle. There is no resume and no done pulse.
- Invariants:
  - frame_n=0 implies irdy_n=0.
  - req_n=0 only in REQ.
  - ad_oe=1 only in XFER.
  - frame_n and irdy_n both 1 outside XFER.

Test Plan:
1. Single beat: cmd_len=0, cmd_base=0xA5, grant 2 cycles after req_n falls, trdy_n=0 -> req_n low for exactly 2 cycles. One XFER cycle with frame_n=1, irdy_n=0, ad_out=0xA5. Then xfer_done pulse and return to IDLE.
2. Burst with waits: cmd_len=3, cmd_base=0x10, trdy_n high for 2 cycles on beat 1 -> ad_out sequence 0x10,0x11,0x11,0x11,0x12,0x13. frame_n rises with the 0x13 beat, and xfer_done fires after it. XFER lasts 6 cycles.
3. Timeout: gnt_n held 1 -> req_n low for exactly 16 cycles, then gnt_timeout pulse and req_n=1. frame_n never asserted; busy=0 afterwards.
4. Grant on timeout edge: gnt_n=0 sampled on the 16th REQ cycle -> XFER entered, no gnt_timeout pulse.
5. Reset mid-burst: reset=0 during beat 2 of an 8-beat burst -> req_n, frame_n and irdy_n=1 and ad_oe=0 immediately. No xfer_done; cmd_ready=1.
6. Back-to-back plus wrap: cmd_valid held high with cmd_base=0xFFFFFFFE, cmd_len=2 -> data 0xFFFFFFFE,0xFFFFFFFF,0x00000000. Second command accepted exactly one cycle after xfer_done. Commands presented while busy are not accepted.
